// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one 8N1 UART transmitter
// between NUM_REQ byte producers, sequencing each byte off the transmitter's busy flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 8,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic [IDW-1:0]       grant_id_o,
    output logic                 locked_o,
    output logic                 err_timeout_o
);

    localparam int          CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int unsigned NR = NUM_REQ;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e                   state_q;
    logic [NUM_REQ-1:0]       req_ready_q;
    logic                     tx_start_q;
    logic [7:0]               tx_data_q;
    logic [IDW-1:0]           grant_id_q;
    logic                     locked_q;
    logic                     err_timeout_q;
    logic                     last_q;
    logic [IDW-1:0]           rr_ptr_q;
    logic [CW-1:0]            cnt_q;

    logic [NUM_REQ-1:0][7:0]  data_arr;
    logic                     sel_found;
    logic [IDW-1:0]           sel_idx;
    logic [IDW-1:0]           cand;

    assign data_arr = req_data_i;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NR;
        return IDW'(s);
    endfunction

    // Descending scan so the candidate closest to rr_ptr (first in rotation) wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_id_q;
        cand      = '0;
        if (locked_q) begin
            sel_found = req_valid_i[grant_id_q];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = wrap_add(rr_ptr_q, k);
                if (req_valid_i[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            locked_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            last_q        <= 1'b0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!tx_busy_i && sel_found) begin
                        grant_id_q  <= sel_idx;
                        tx_data_q   <= data_arr[sel_idx];
                        last_q      <= req_last_i[sel_idx];
                        req_ready_q <= NUM_REQ'(1) << sel_idx;
                        tx_start_q  <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_start_q  <= 1'b0;
                    req_ready_q <= '0;
                    cnt_q       <= '0;
                    state_q     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: abandon the packet and move on.
                        err_timeout_q <= 1'b1;
                        locked_q      <= 1'b0;
                        rr_ptr_q      <= wrap_add(grant_id_q, 1);
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        state_q <= IDLE;
                        if (last_q) begin
                            locked_q <= 1'b0;
                            rr_ptr_q <= wrap_add(grant_id_q, 1);
                        end else begin
                            locked_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign grant_id_o    = grant_id_q;
    assign locked_o      = locked_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a simple transmitter
// busy model and a queue-level round-robin/lock reference model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            locked;
    logic            err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .tx_start_o    (tx_start),
        .tx_data_o     (tx_data),
        .tx_busy_i     (tx_busy),
        .grant_id_o    (grant_id),
        .locked_o      (locked),
        .err_timeout_o (err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] rq [NR][$];        // {last, data} per requester
    bit   m_locked = 0;
    int   m_owner  = 0;
    int   m_ptr    = 0;
    int   m_g      = 0;
    bit   tx_en    = 1;
    int   busy_left = 0;
    bit   start_seen = 0;
    bit   prev_start = 0;
    int   cyc = 0, t_start = 0, t_err = 0, err_cnt = 0, start_cnt = 0;
    int         obs_id   [$];
    logic [7:0] obs_data [$];
    bit         obs_lock [$];

    typedef struct {
        logic [NR-1:0]   load;
        logic [7:0]      base;
        int              n;
        logic [3:0][1:0] ord;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or impossible event (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [3:0][1:0] o4(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    // Reference arbitration: owner if locked, else first valid in rotation from m_ptr.
    function automatic int pick(input logic [NR-1:0] v);
        int idx;
        if (m_locked) return (((v >> m_owner) & NR'(1)) != 0) ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (((v >> idx) & NR'(1)) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (rq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        logic [NR-1:0]   v, l;
        logic [8*NR-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                v = v | (NR'(1) << i);
                if (rq[i][0][8]) l = l | (NR'(1) << i);
                d = d | ((8*NR)'(rq[i][0][7:0]) << (8 * i));
            end
        end
        req_valid = v; req_last = l; req_data = d;
    endtask

    task automatic step();
        logic [NR-1:0] pv;
        logic [8:0]    fr;
        int            g;
        bit            inv_ok;
        @(posedge clk); #1;
        cyc++;
        pv = req_valid;
        if (tx_en) begin
            if (start_seen) busy_left = $urandom_range(2, 6);
            tx_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
        inv_ok = ($countones(req_ready) <= 1) && (req_ready == '0 || tx_start) && !(tx_start && prev_start);
        chk("step_invariants", 32'(inv_ok), 1);
        if (tx_start) begin
            start_cnt++;
            t_start = cyc;
            obs_id.push_back(int'(grant_id));
            obs_data.push_back(tx_data);
            obs_lock.push_back(locked);
            g = pick(pv);
            if (g < 0) bound_fail("start_without_eligible_request");
            else begin
                chk("grant_id", 32'(grant_id), g);
                chk("req_ready", 32'(req_ready), 32'(1) << g);
                chk("locked_at_issue", 32'(locked), 32'(m_locked));
                if (rq[g].size() == 0) bound_fail("start_with_empty_queue");
                else begin
                    fr = rq[g][0];
                    chk("tx_data", 32'(tx_data), 32'(fr[7:0]));
                    m_g = g;
                    if (fr[8]) begin m_locked = 0; m_ptr = (g + 1) % NR; end
                    else begin m_locked = 1; m_owner = g; end
                end
            end
        end
        if (err_timeout) begin
            err_cnt++;
            t_err    = cyc;
            m_locked = 0;
            m_ptr    = (m_g + 1) % NR;
        end
        prev_start = tx_start;
        start_seen = tx_start;
        for (int i = 0; i < NR; i++)
            if (((req_ready >> i) & NR'(1)) != 0 && rq[i].size() > 0) void'(rq[i].pop_front());
        drive();
    endtask

    task automatic run_drain(input int budget);
        int c;
        c = 0;
        while (pending() && c < budget) begin step(); c++; end
        if (c >= budget) bound_fail("drain_budget");
        repeat (20) step();
    endtask

    task automatic wait_start(input int budget);
        int s0, c;
        s0 = start_cnt; c = 0;
        while (start_cnt == s0 && c < budget) begin step(); c++; end
        if (start_cnt == s0) bound_fail("wait_tx_start");
    endtask

    task automatic clear_obs();
        obs_id.delete(); obs_data.delete(); obs_lock.delete();
    endtask

    task automatic chk_seq(input string nm, input int k, input int id, input logic [7:0] d);
        if (k >= obs_id.size()) bound_fail(nm);
        else begin
            chk({nm, "_id"}, 32'(obs_id[k]), id);
            chk({nm, "_data"}, 32'(obs_data[k]), 32'(d));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, pushed, r, len;

        tbl[0] = '{4'b1111, 8'hA0, 4, o4(0, 1, 2, 3)};
        tbl[1] = '{4'b1111, 8'hB0, 4, o4(0, 1, 2, 3)};
        tbl[2] = '{4'b0010, 8'h54, 1, o4(1, 0, 0, 0)};
        tbl[3] = '{4'b0011, 8'h60, 2, o4(0, 1, 0, 0)};
        tbl[4] = '{4'b1000, 8'h70, 1, o4(3, 0, 0, 0)};
        tbl[5] = '{4'b1100, 8'h80, 2, o4(2, 3, 0, 0)};
        tbl[6] = '{4'b1001, 8'h90, 2, o4(0, 3, 0, 0)};
        tbl[7] = '{4'b0110, 8'hC0, 2, o4(1, 2, 0, 0)};
        tbl[8] = '{4'b0101, 8'hD0, 2, o4(0, 2, 0, 0)};
        tbl[9] = '{4'b1110, 8'hE0, 3, o4(3, 1, 2, 0)};

        rst_n = 1'b0; tx_busy = 1'b0;
        drive();
        step(); step();
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_start", 32'(tx_start), 0);
        chk("reset_data", 32'(tx_data), 0);
        chk("reset_grant", 32'(grant_id), 0);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_err", 32'(err_timeout), 0);
        rst_n = 1'b1;
        step();

        // Round-robin vectors, all single-byte packets
        for (int e = 0; e < 10; e++) begin
            clear_obs();
            for (int i = 0; i < NR; i++)
                if (((tbl[e].load >> i) & NR'(1)) != 0) rq[i].push_back({1'b1, 8'(tbl[e].base + 8'(i))});
            run_drain(400);
            chk("tbl_count", 32'(obs_id.size()), tbl[e].n);
            for (int k = 0; k < tbl[e].n; k++)
                chk_seq("tbl", k, int'(tbl[e].ord[k]), 8'(tbl[e].base + 8'(tbl[e].ord[k])));
        end

        // Packet lock: requester 0 must wait for requester 2's whole packet
        clear_obs();
        rq[2].push_back({1'b0, 8'h11});
        rq[2].push_back({1'b0, 8'h22});
        rq[2].push_back({1'b1, 8'h33});
        wait_start(50);
        rq[0].push_back({1'b1, 8'h99});
        run_drain(400);
        chk_seq("lock0", 0, 2, 8'h11);
        chk_seq("lock1", 1, 2, 8'h22);
        chk_seq("lock2", 2, 2, 8'h33);
        chk_seq("lock3", 3, 0, 8'h99);
        if (obs_lock.size() == 4) begin
            chk("lock_flag0", 32'(obs_lock[0]), 0);
            chk("lock_flag1", 32'(obs_lock[1]), 1);
            chk("lock_flag2", 32'(obs_lock[2]), 1);
            chk("lock_flag3", 32'(obs_lock[3]), 0);
        end else bound_fail("lock_flag_count");

        // Timeout: transmitter never raises busy
        clear_obs();
        tx_en = 0; tx_busy = 1'b0; busy_left = 0;
        e0 = err_cnt;
        rq[1].push_back({1'b1, 8'h5A});
        rq[2].push_back({1'b1, 8'h6B});
        wait_start(50);
        begin
            int c;
            c = 0;
            while (err_cnt == e0 && c < 40) begin step(); c++; end
        end
        if (err_cnt == e0) bound_fail("timeout_no_err");
        else begin
            chk("timeout_latency", 32'(t_err - t_start), TO + 1);
            chk("timeout_locked", 32'(locked), 0);
        end
        tx_en = 1;
        run_drain(400);
        chk("timeout_err_pulses", 32'(err_cnt - e0), 1);
        chk_seq("timeout0", 0, 1, 8'h5A);
        chk_seq("timeout1", 1, 2, 8'h6B);

        // Reset during WAIT_DONE of a locked packet
        clear_obs();
        rq[3].push_back({1'b0, 8'hC1});
        rq[3].push_back({1'b0, 8'hC2});
        rq[3].push_back({1'b1, 8'hC3});
        wait_start(50);
        wait_start(100);
        step(); step();
        chk("pre_reset_locked", 32'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 0);
        chk("midrst_start", 32'(tx_start), 0);
        chk("midrst_data", 32'(tx_data), 0);
        chk("midrst_grant", 32'(grant_id), 0);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_err", 32'(err_timeout), 0);
        for (int i = 0; i < NR; i++) rq[i].delete();
        tx_busy = 1'b0; busy_left = 0; start_seen = 0; prev_start = 0;
        m_locked = 0; m_ptr = 0;
        drive();
        step(); step();
        rst_n = 1'b1;
        clear_obs();
        rq[0].push_back({1'b1, 8'hD0});
        rq[2].push_back({1'b1, 8'hD2});
        run_drain(400);
        chk_seq("post_reset0", 0, 0, 8'hD0);
        chk_seq("post_reset1", 1, 2, 8'hD2);

        // Busy already high in IDLE blocks selection; then rr_ptr wraps 3 -> 0
        clear_obs();
        tx_en = 0; tx_busy = 1'b1;
        rq[3].push_back({1'b1, 8'hE3});
        s0 = start_cnt;
        repeat (12) step();
        chk("busy_block_starts", 32'(start_cnt - s0), 0);
        tx_busy = 1'b0; busy_left = 0; tx_en = 1;
        run_drain(400);
        chk_seq("busy_release", 0, 3, 8'hE3);
        clear_obs();
        rq[3].push_back({1'b1, 8'hF3});
        rq[0].push_back({1'b1, 8'hF0});
        run_drain(400);
        chk_seq("wrap0", 0, 0, 8'hF0);
        chk_seq("wrap1", 1, 3, 8'hF3);

        // Randomized traffic against the reference model
        clear_obs();
        s0 = start_cnt; e0 = err_cnt; pushed = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, NR - 1);
                if (rq[r].size() < 6) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) rq[r].push_back({1'(b == len - 1), 8'($urandom)});
                    pushed += len;
                end
            end
            step();
        end
        run_drain(3000);
        chk("rand_bytes_sent", 32'(start_cnt - s0), pushed);
        chk("rand_no_timeout", 32'(err_cnt - e0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
